lod_normalizer: RTL and testbench

LOD_NORMALIZER -- requirements
Module: lod_normalizer

---
 rtl/lod_pkg.sv | 15 +
 rtl/lod_normalizer_pipe_stage_ctl.sv | 37 +++
 rtl/lod_normalizer.sv | 132 +++++++++++++
 tb/tb_lod_normalizer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lod_pkg.sv
// Shared constants for the leading-one detect / normalize path.
package lod_pkg;

   localparam int LOD_DATA_W = 9;
   localparam int LOD_IDX_W  = 5;

   // Index value the detector emits for an all-zero operand.
   localparam logic [LOD_IDX_W-1:0] IDX_ZERO = '1;

   // Bits needed to hold a left-shift amount of 0..data_w-1.
   function automatic int sh_width(input int data_w);
      return (data_w > 2) ? $clog2(data_w) : 1;
   endfunction

endpackage

// File: rtl/lod_normalizer_pipe_stage_ctl.sv
// Valid/ready bookkeeping for one pipeline register stage, no skid buffer.
module pipe_stage_ctl (
   input  logic clk,
   input  logic rst,
   input  logic up_valid,
   input  logic down_ready,
   output logic valid,
   output logic ready,
   output logic load
);

   logic valid_q;
   logic valid_d;

   // Stage accepts when empty or when its contents leave this same cycle.
   assign ready = !valid_q || down_ready;
   assign load  = up_valid && ready;
   assign valid = valid_q;

   // Next occupancy: a load keeps/sets it, a bare transfer onward empties it.
   always_comb begin
      valid_d = valid_q;
      if (load)
         valid_d = 1'b1;
      else if (valid_q && down_ready)
         valid_d = 1'b0;
   end

   // Occupancy register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         valid_q <= 1'b0;
      else
         valid_q <= valid_d;
   end

endmodule

// File: rtl/lod_normalizer.sv
// Two-stage normalizer: shifts an operand so its leading one lands at the MSB,
// using the index supplied by the upstream leading-one detector.
module lod_normalizer
   import lod_pkg::*;
#(
   parameter int DATA_W = LOD_DATA_W,
   parameter int IDX_W  = LOD_IDX_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [IDX_W-1:0]  in_idx,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_mant,
   output logic [IDX_W-1:0]  out_exp,
   output logic              out_zero,
   output logic              err_idx
);

   localparam int SH_W = sh_width(DATA_W);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_W - 1);

   logic in_is_zero;
   logic in_bad;

   logic s1_valid, s1_ready, s1_load;
   logic s2_valid, s2_ready, s2_load;

   logic [DATA_W-1:0] s1_data_q, s1_data_d;
   logic [IDX_W-1:0]  s1_idx_q,  s1_idx_d;
   logic              s1_zero_q, s1_zero_d;
   logic [SH_W-1:0]   s1_sh_q,   s1_sh_d;

   logic [DATA_W-1:0] s2_mant_q, s2_mant_d;
   logic [IDX_W-1:0]  s2_exp_q,  s2_exp_d;
   logic              s2_zero_q, s2_zero_d;

   logic              err_q, err_d;

   // All-ones index means zero operand; anything else above the MSB position
   // is illegal and is flushed through as zero.
   assign in_is_zero = (in_idx == '1);
   assign in_bad     = !in_is_zero && (in_idx > IDX_MAX);

   pipe_stage_ctl u_s1_ctl (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (in_valid),
      .down_ready (s2_ready),
      .valid      (s1_valid),
      .ready      (s1_ready),
      .load       (s1_load)
   );

   pipe_stage_ctl u_s2_ctl (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (s1_valid),
      .down_ready (out_ready),
      .valid      (s2_valid),
      .ready      (s2_ready),
      .load       (s2_load)
   );

   assign in_ready  = s1_ready;
   assign out_valid = s2_valid;
   assign out_mant  = s2_mant_q;
   assign out_exp   = s2_exp_q;
   assign out_zero  = s2_zero_q;
   assign err_idx   = err_q;

   // S1 capture: raw operand, index, zero classification and shift amount.
   always_comb begin
      s1_data_d = s1_data_q;
      s1_idx_d  = s1_idx_q;
      s1_zero_d = s1_zero_q;
      s1_sh_d   = s1_sh_q;
      if (s1_load) begin
         s1_data_d = in_data;
         s1_idx_d  = in_idx;
         s1_zero_d = in_is_zero || in_bad;
         if (in_is_zero || in_bad)
            s1_sh_d = '0;
         else
            s1_sh_d = SH_W'(DATA_W - 1) - SH_W'(in_idx);
      end
   end

   // S2 capture: normalized mantissa; zero operands force a clean zero.
   always_comb begin
      s2_mant_d = s2_mant_q;
      s2_exp_d  = s2_exp_q;
      s2_zero_d = s2_zero_q;
      if (s2_load) begin
         s2_mant_d = s1_zero_q ? '0 : (s1_data_q << s1_sh_q);
         s2_exp_d  = s1_idx_q;
         s2_zero_d = s1_zero_q;
      end
   end

   // Sticky illegal-index flag, set when a bad index is accepted.
   always_comb begin
      err_d = err_q | (s1_load & in_bad);
   end

   // Pipeline data and error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_data_q <= '0;
         s1_idx_q  <= '0;
         s1_zero_q <= 1'b0;
         s1_sh_q   <= '0;
         s2_mant_q <= '0;
         s2_exp_q  <= '0;
         s2_zero_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         s1_data_q <= s1_data_d;
         s1_idx_q  <= s1_idx_d;
         s1_zero_q <= s1_zero_d;
         s1_sh_q   <= s1_sh_d;
         s2_mant_q <= s2_mant_d;
         s2_exp_q  <= s2_exp_d;
         s2_zero_q <= s2_zero_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_lod_normalizer.sv
// Self-checking bench for lod_normalizer with an in-order result scoreboard.
module tb_lod_normalizer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [8:0] in_data;
   logic [4:0] in_idx;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] out_mant;
   logic [4:0] out_exp;
   logic       out_zero;
   logic       err_idx;

   always #5 clk = ~clk;

   lod_normalizer #(.DATA_W(9), .IDX_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_idx    (in_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mant  (out_mant),
      .out_exp   (out_exp),
      .out_zero  (out_zero),
      .err_idx   (err_idx)
   );

   typedef struct packed {
      logic [8:0] mant;
      logic [4:0] exp;
      logic       zero;
   } res_t;

   res_t sb_q[$];
   res_t mon_e;
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   rnd_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   function automatic res_t model(input logic [8:0] d, input logic [4:0] i);
      res_t        r;
      logic [17:0] w;
      int          sh;
      r.exp = i;
      if (i > 5'd8) begin
         r.zero = 1'b1;
         r.mant = 9'd0;
      end else begin
         sh     = 8 - int'(i);
         w      = 18'(d) << sh;
         r.zero = 1'b0;
         r.mant = w[8:0];
      end
      return r;
   endfunction

   // Scoreboard: pop on output transfer, push on input transfer.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0)
               chk("spurious_out", {31'd0, out_valid}, 32'd0);
            else begin
               mon_e = sb_q.pop_front();
               chk("sb_mant", out_mant, mon_e.mant);
               chk("sb_exp",  out_exp,  mon_e.exp);
               chk("sb_zero", out_zero, mon_e.zero);
            end
         end
         if (in_valid && in_ready)
            sb_q.push_back(model(in_data, in_idx));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [8:0] d, input logic [4:0] i);
      bit ok;
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_idx   = i;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      chk("drain_empty", sb_q.size(), 32'd0);
   endtask

   initial begin
      logic [8:0] st_d   [3];
      logic [4:0] st_i   [3];
      logic [8:0] st_m   [3];
      logic [4:0] st_e   [3];
      logic [8:0] bp_d   [4];
      logic [4:0] bp_i   [4];
      res_t       bp_exp0;
      int         accepted;
      int         sel;

      st_d = '{9'h100, 9'h001, 9'h0AA};
      st_i = '{5'd8, 5'd0, 5'd7};
      st_m = '{9'h100, 9'h100, 9'h154};
      st_e = '{5'd8, 5'd0, 5'd7};
      bp_d = '{9'h0F0, 9'h033, 9'h1FF, 9'h005};
      bp_i = '{5'd7, 5'd5, 5'd8, 5'd2};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_idx = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_mant",      out_mant,  0);
      chk("rst_exp",       out_exp,   0);
      chk("rst_zero",      out_zero,  0);
      chk("rst_err",       err_idx,   0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      tick();

      // Single operand, latency 2.
      send(9'b000010110, 5'd4);
      in_valid = 1'b0;
      chk("lat1_valid", out_valid, 0);
      tick();
      chk("lat2_valid", out_valid, 1);
      chk("basic_mant", out_mant,  9'b101100000);
      chk("basic_exp",  out_exp,   4);
      chk("basic_zero", out_zero,  0);
      tick();

      // Zero operand.
      send(9'd0, 5'b11111);
      in_valid = 1'b0;
      tick();
      chk("zero_valid", out_valid, 1);
      chk("zero_zero",  out_zero,  1);
      chk("zero_mant",  out_mant,  0);
      chk("zero_exp",   out_exp,   5'b11111);
      chk("zero_err",   err_idx,   0);
      tick();

      // Back-to-back stream, results on consecutive cycles.
      send(st_d[0], st_i[0]);
      for (int k = 1; k < 3; k++) begin
         send(st_d[k], st_i[k]);
         chk("stream_valid", out_valid, 1);
         chk("stream_mant",  out_mant,  st_m[k-1]);
         chk("stream_exp",   out_exp,   st_e[k-1]);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_mant",  out_mant,  st_m[2]);
      chk("stream_exp",   out_exp,   st_e[2]);
      tick(); tick();

      // Backpressure: 5 stalled cycles, 4 operands offered.
      out_ready = 1'b0;
      accepted  = 0;
      sel       = 0;
      bp_exp0   = model(bp_d[0], bp_i[0]);
      for (int c = 1; c <= 5; c++) begin
         in_valid = 1'b1;
         in_data  = bp_d[sel];
         in_idx   = bp_i[sel];
         @(negedge clk);
         chk("bp_in_ready", in_ready, (c <= 2) ? 1 : 0);
         if (c >= 3) begin
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_mant",  out_mant,  bp_exp0.mant);
            chk("bp_hold_exp",   out_exp,   bp_exp0.exp);
         end
         if (in_ready) begin
            accepted++;
            if (sel < 3) sel++;
         end
         @(posedge clk); #1;
      end
      chk("bp_accepted", accepted, 2);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain();
      tick();

      // Illegal index sets sticky error.
      send(9'h1FF, 5'd12);
      in_valid = 1'b0;
      tick();
      chk("bad_valid", out_valid, 1);
      chk("bad_zero",  out_zero,  1);
      chk("bad_mant",  out_mant,  0);
      chk("bad_exp",   out_exp,   12);
      chk("bad_err",   err_idx,   1);
      send(9'h003, 5'd1);
      send(9'h040, 5'd6);
      in_valid = 1'b0;
      repeat (3) tick();
      chk("err_sticky", err_idx, 1);

      // Reset with both stages full.
      out_ready = 1'b0;
      send(9'h011, 5'd4);
      send(9'h022, 5'd5);
      in_valid = 1'b0;
      chk("full_valid",    out_valid, 1);
      chk("full_in_ready", in_ready,  0);
      #2 rst = 1'b1;
      sb_q.delete();
      #1;
      chk("async_rst_valid",    out_valid, 0);
      chk("async_rst_in_ready", in_ready,  1);
      chk("async_rst_err",      err_idx,   0);
      chk("async_rst_mant",     out_mant,  0);
      out_ready = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("no_stale_valid", out_valid, 0);
      end
      tick();

      // Random stream with random backpressure.
      rnd_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 40; k++) begin
               int         ri;
               logic [8:0] rd;
               ri = int'($urandom_range(0, 9));
               if (ri == 9) begin
                  send(9'd0, 5'b11111);
               end else begin
                  rd = 9'($urandom) & 9'((1 << ri) - 1);
                  rd = rd | 9'(1 << ri);
                  send(rd, 5'(ri));
               end
               if ($urandom_range(0, 3) == 0) begin
                  in_valid = 1'b0;
                  tick();
               end
            end
            in_valid = 1'b0;
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               out_ready = 1'($urandom_range(0, 1));
               tick();
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();
      chk("final_err_clear", err_idx, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
